// File: rtl/crc8_fsk_encoder.sv
// CRC-8 (poly 0x07) transmit encoder: serial CRC over one byte, then streams {data, crc} MSB-first as symbols.
// Optional macro CRC_INV_LSB_EN inverts the two CRC LSBs in the transmitted codeword.
module crc8_fsk_encoder #(
  parameter int K            = 8,
  parameter int BITS_PER_SYM = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [K-1:0]            in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BITS_PER_SYM-1:0] sym_out,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_last,
  output logic [15:0]             codeword,
  output logic                    busy
);
  localparam int N_SYM = 16 / BITS_PER_SYM;
  localparam int SCW   = $clog2(N_SYM);

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t                  state_q;
  logic [K-1:0]            data_q;
  logic [7:0]              crc_q;
  logic [2:0]              bit_cnt_q;
  logic [SCW-1:0]          sym_cnt_q;
  logic [15:0]             codeword_q;
  logic [BITS_PER_SYM-1:0] sym_out_q;
  logic                    sym_valid_q, sym_last_q, in_ready_q, busy_q;

  logic [7:0]              crc_d;
  logic [15:0]             codeword_d;
  logic [SCW-1:0]          sym_cnt_d;

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Symbol idx is the idx-th BITS_PER_SYM-wide slice counted from the codeword MSB.
  function automatic logic [BITS_PER_SYM-1:0] sym_slice(input logic [15:0] cw, input logic [SCW-1:0] idx);
    logic [15:0] sh;
    sh = cw << (idx * BITS_PER_SYM);
    return sh[15 -: BITS_PER_SYM];
  endfunction

  always_comb begin
    crc_d = crc_step(crc_q, data_q[3'd7 - bit_cnt_q]);
`ifdef CRC_INV_LSB_EN
    codeword_d = {data_q, crc_d[7:2], ~crc_d[1:0]};
`else
    codeword_d = {data_q, crc_d};
`endif
    sym_cnt_d = sym_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      crc_q       <= '0;
      bit_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      codeword_q  <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            crc_q      <= '0;
            bit_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          crc_q     <= crc_d;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            codeword_q  <= codeword_d;
            sym_cnt_q   <= '0;
            sym_out_q   <= sym_slice(codeword_d, '0);
            sym_last_q  <= 1'b0;
            sym_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // sym_valid is always high here, so sym_ready alone completes a handshake.
          if (sym_ready) begin
            if (sym_last_q) begin
              sym_valid_q <= 1'b0;
              sym_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              sym_cnt_q  <= sym_cnt_d;
              sym_out_q  <= sym_slice(codeword_q, sym_cnt_d);
              sym_last_q <= (sym_cnt_d == SCW'(N_SYM - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign sym_out   = sym_out_q;
  assign sym_valid = sym_valid_q;
  assign sym_last  = sym_last_q;
  assign codeword  = codeword_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_crc8_fsk_encoder.sv
// Self-checking bench for crc8_fsk_encoder: directed vectors, backpressure, input blocking,
// mid-frame reset, random payloads, plus BITS_PER_SYM=1 and 4 instances.
module tb_crc8_fsk_encoder;
`ifdef CRC_INV_LSB_EN
  localparam logic [15:0] INV = 16'h0003;
`else
  localparam logic [15:0] INV = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in_data;
  logic in_valid, in_ready, sym_valid, sym_ready, sym_last, busy;
  logic [1:0] sym_out;
  logic [15:0] codeword;

  logic [7:0] in_data_a;
  logic in_valid_a, sym_ready_a;
  logic in_ready1, sym_valid1, sym_last1, busy1;
  logic [0:0] sym_out1;
  logic [15:0] codeword1;
  logic in_ready4, sym_valid4, sym_last4, busy4;
  logic [3:0] sym_out4;
  logic [15:0] codeword4;

  int nassert = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  crc8_fsk_encoder #(.K(8), .BITS_PER_SYM(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_last(sym_last),
    .codeword(codeword), .busy(busy));

  crc8_fsk_encoder #(.K(8), .BITS_PER_SYM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready1),
    .sym_out(sym_out1), .sym_valid(sym_valid1), .sym_ready(sym_ready_a), .sym_last(sym_last1),
    .codeword(codeword1), .busy(busy1));

  crc8_fsk_encoder #(.K(8), .BITS_PER_SYM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready4),
    .sym_out(sym_out4), .sym_valid(sym_valid4), .sym_ready(sym_ready_a), .sym_last(sym_last4),
    .codeword(codeword4), .busy(busy4));

  // Reference: remainder of data*x^8 divided by x^8+x^2+x+1, by polynomial long division.
  function automatic logic [15:0] ref_cw(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    return {d, r[7:0]} ^ INV;
  endfunction

  function automatic int sym_of(input logic [15:0] cw, input int k, input int bps);
    return int'((cw >> (16 - (k + 1) * bps)) & ((16'd1 << bps) - 16'd1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bp: 0 = sym_ready tied high, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic frame(input logic [7:0] d, input logic [15:0] exp_cw, input int bp,
                       input bit keep_valid, input logic [7:0] nxt);
    int cyc, k, guard;
    in_data   = d;
    in_valid  = 1'b1;
    sym_ready = 1'b0;
    step();
    check("hs_in_ready", in_ready, 0);
    check("hs_busy", busy, 1);
    if (keep_valid) in_data = nxt;
    else in_valid = 1'b0;
    cyc = 0;
    while (!sym_valid && cyc < 20) begin
      check("calc_in_ready", in_ready, 0);
      step();
      cyc++;
    end
    check("latency", cyc, 8);
    check("codeword", codeword, exp_cw);
    k = 0;
    guard = 0;
    while (k < 8 && guard < 200) begin
      case (bp)
        0:       sym_ready = 1'b1;
        1:       sym_ready = (guard % 3 == 0);
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
      check("sym_valid", sym_valid, 1);
      check("sym_out", sym_out, sym_of(exp_cw, k, 2));
      check("sym_last", sym_last, (k == 7));
      check("send_in_ready", in_ready, 0);
      check("cw_stable", codeword, exp_cw);
      if (sym_ready) k++;
      step();
      guard++;
    end
    check("handshakes", k, 8);
    check("end_sym_valid", sym_valid, 0);
    check("end_sym_last", sym_last, 0);
    check("end_busy", busy, 0);
    check("end_in_ready", in_ready, 1);
    sym_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b, r;
    logic [15:0] e;
    int cyc;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; sym_ready = 1'b0;
    in_data_a = '0; in_valid_a = 1'b0; sym_ready_a = 1'b1;

    repeat (3) begin
      step();
      check("rst_outs", {in_ready, sym_out, sym_valid, sym_last, busy}, 0);
      check("rst_cw", codeword, 0);
    end
    rst_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_sym_valid", sym_valid, 0);
    check("rel_busy", busy, 0);

    frame(8'h01, 16'h0107 ^ INV, 0, 1'b0, 8'h00);
    frame(8'h80, 16'h8089 ^ INV, 0, 1'b0, 8'h00);
    frame(8'hFF, 16'hFFF3 ^ INV, 0, 1'b0, 8'h00);
    frame(8'h31, 16'h3197 ^ INV, 0, 1'b0, 8'h00);
    frame(8'h31, 16'h3197 ^ INV, 1, 1'b0, 8'h00);
    check("cw_hold_idle", codeword, 16'h3197 ^ INV);

    a = 8'($urandom);
    b = 8'($urandom);
    frame(a, ref_cw(a), 0, 1'b1, b);
    frame(b, ref_cw(b), 2, 1'b0, 8'h00);
    repeat (6) begin
      r = 8'($urandom);
      frame(r, ref_cw(r), 2, 1'b0, 8'h00);
    end

    // Reset after the third symbol of 0xFF.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!sym_valid && cyc < 20) begin step(); cyc++; end
    check("mid_latency", cyc, 8);
    sym_ready = 1'b1;
    repeat (3) step();
    check("mid_sym4", sym_out, sym_of(16'hFFF3 ^ INV, 3, 2));
    rst_n = 1'b0;
    step();
    check("mid_rst_sym_valid", sym_valid, 0);
    check("mid_rst_cw", codeword, 0);
    check("mid_rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_no_sym", sym_valid, 0);
    end
    check("post_rst_in_ready", in_ready, 1);
    frame(8'h01, 16'h0107 ^ INV, 0, 1'b0, 8'h00);

    // BITS_PER_SYM = 1 and 4 instances, both fed 0xFF with sym_ready held high.
    e = 16'hFFF3 ^ INV;
    in_data_a = 8'hFF; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    repeat (7) step();
    check("w1_not_yet", sym_valid1, 0);
    step();
    check("w1_cw", codeword1, e);
    check("w4_cw", codeword4, e);
    for (int k = 0; k < 16; k++) begin
      check("w1_valid", sym_valid1, 1);
      check("w1_sym", sym_out1, sym_of(e, k, 1));
      check("w1_last", sym_last1, (k == 15));
      if (k < 4) begin
        check("w4_sym", sym_out4, sym_of(e, k, 4));
        check("w4_last", sym_last4, (k == 3));
      end else if (k == 4) begin
        check("w4_done", sym_valid4, 0);
        check("w4_in_ready", in_ready4, 1);
      end
      step();
    end
    check("w1_done", sym_valid1, 0);
    check("w1_in_ready", in_ready1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/crc8_fsk_encoder.md
Name: crc8_fsk_encoder

Overview:
Transmit-side counterpart of the CRC-8 receive checker. It accepts one K-bit data byte per frame and computes the CRC-8 remainder bit-serially (poly x^8+x^2+x+1, 0x07, init 0x00, MSB-first, no reflection, no final XOR). It forms the 16-bit codeword {data, crc} and streams that codeword MSB-first as BITS_PER_SYM-bit symbols to the 4FSK modulator. Each codeword divides exactly by the polynomial, so the receive checker reports remainder 0.

Parameters:
K, 8, data width; 8 is the only supported value (codeword fixed at 16 bits).
BITS_PER_SYM, 2, bits per output symbol; legal values 1, 2, 4. 2 selects 4FSK. N_SYM = 16/BITS_PER_SYM.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
in_data  input  K  payload byte.
in_valid  input  1  payload valid.
in_ready  output  1  encoder can accept a payload.
sym_out  output  BITS_PER_SYM  current symbol, MSB-first slice of the codeword.
sym_valid  output  1  sym_out is valid.
sym_ready  input  1  modulator accepts the symbol.
sym_last  output  1  marks the final symbol of the codeword.
codeword  output  16  {data, crc}; stable from the first sym_valid until the frame completes.
busy  output  1  high in CALC and SEND.

Behaviour:
- Reset: when rst_n is sampled low at a clk edge, state goes to IDLE. All outputs reset to 0: in_ready, sym_out, sym_valid, sym_last, codeword, busy, and the internal crc/bit/symbol counters. in_ready rises at the first edge that samples rst_n high. A reset mid-frame aborts the frame with no further symbols.
- All outputs are registered.
- FSM states: IDLE, CALC, SEND.
- IDLE: in_ready=1, busy=0. A handshake (in_valid & in_ready) at edge T latches in_data, clears crc to 0x00 and bit_cnt to 0, and moves to CALC. in_ready=0 from T.
- CALC: runs exactly 8 cycles, one data bit per cycle, MSB first. Per cycle: fb = crc[7] ^ d[7-bit_cnt]; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00). in_valid is ignored.
- At the 8th CALC edge (T+8): codeword <= {data, crc_final}, sym_cnt <= 0, state -> SEND, sym_valid <= 1.
- Latency: the first symbol is valid in the cycle after edge T+8, i.e. 8 cycles after the payload handshake.
- SEND: sym_out = codeword[15 - sym_cnt*BITS_PER_SYM -: BITS_PER_SYM]. sym_last = (sym_cnt == N_SYM-1).
- Symbol handshake: on sym_valid & sym_ready, sym_cnt increments. While sym_ready is low, sym_out, sym_last and sym_valid hold stable (no symbol drops, no glitching).
- Frame end: a handshake on the last symbol sets sym_valid=0, sym_last=0, busy=0, in_ready=1 and moves to IDLE at that edge. A new payload can be accepted the cycle after. Frames never overlap.
- Throughput: at most one frame per 8+N_SYM+1 cycles.
- sym_ready high while sym_valid is low has no effect.
- codeword holds its last value in IDLE; it is not cleared except by reset.

Optional Feature:
Macro CRC_INV_LSB_EN. When defined, the transmitted codeword and symbols use {data, crc[7:2], ~crc[1], ~crc[0]}, matching a receiver that re-inverts the two LSBs before checking. When undefined, the codeword is the plain {data, crc}. The CALC cycle count and timing are identical either way.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release. All outputs are 0 during reset, in_ready=1 on the first cycle after release, sym_valid=0.
- Known vectors, sym_ready tied 1, BITS_PER_SYM=2:
  - 0x01 -> codeword 0x0107, symbols 0,0,0,1,0,0,1,3.
  - 0x80 -> 0x8089.
  - 0xFF -> 0xFFF3, symbols 3,3,3,3,3,3,0,3.
  - 0x31 -> 0x3197.
  - sym_last is high only on the 8th symbol.
  - First sym_valid occurs 8 cycles after the in_valid handshake.
- Backpressure: send 0x31 with sym_ready toggling 1,0,0,1,... sym_out holds during stalls, the sequence is 0,3,0,1,2,1,1,3, and exactly 8 handshakes occur.
- Input blocking: hold in_valid=1 with new data throughout a frame. in_ready=0 during CALC/SEND, the second payload is accepted only on the cycle after the last symbol, and the first frame is uncorrupted.
- Reset mid-SEND: assert rst_n=0 after the 3rd symbol of 0xFF. Next cycle sym_valid=0, codeword=0, and no remaining symbols are emitted. After release, payload 0x01 yields 0x0107.
- Macro/parameter sweep:
  - With CRC_INV_LSB_EN, 0x01 -> 0x0104 and 0xFF -> 0xFFF0.
  - BITS_PER_SYM=1 gives 16 single-bit symbols with the last on cycle 16.
  - BITS_PER_SYM=4 with 0xFF gives F,F,F,3.
